// File: rtl/fp_pkg.sv
// Shared constants and field helpers for the parametrised floating-point datapath.
// Field positions and special patterns are functions because they depend on the instance widths.
package fp_pkg;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;
  localparam int FLAGS_W       = 3;

  // Wide enough for binary64 and beyond; callers cast down to their own word width.
  localparam int PAT_W = 128;

  function automatic int sign_pos(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction

  function automatic int exp_pos(input int man_w);
    return man_w;
  endfunction

  function automatic logic [PAT_W-1:0] inf_pat(input int exp_w, input int man_w);
    logic [PAT_W-1:0] p;
    p = '0;
    for (int i = 0; i < exp_w; i++) p[man_w+i] = 1'b1;
    return p;
  endfunction

  function automatic logic [PAT_W-1:0] qnan_pat(input int exp_w, input int man_w);
    logic [PAT_W-1:0] p;
    p = inf_pat(exp_w, man_w);
    p[man_w-1] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise, round-to-nearest-even and range-check a raw significand sum.
// Input sum layout: {carry, hidden, fraction, guard, round, sticky}.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_sign,
  input  logic [EXP_W-1:0]     i_exp,
  input  logic [MAN_W+4:0]     i_sum,
  output logic [EXP_W+MAN_W:0] o_res,
  output logic                 o_overflow,
  output logic                 o_inexact
);

  localparam int EW   = EXP_W + 2;
  localparam int LZ_W = $clog2(MAN_W + 5) + 1;
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

  logic [LZ_W-1:0]         w_lzc;
  logic [MAN_W+3:0]        w_norm;
  logic signed [EW-1:0]    w_exp_n;
  logic signed [EW-1:0]    w_exp_r;
  logic                    w_round_up;
  logic [MAN_W+1:0]        w_mant_r;
  logic [MAN_W-1:0]        w_frac;

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i <= MAN_W + 3; i++) begin
      if (i_sum[i]) w_lzc = LZ_W'(MAN_W + 3 - i);
    end

    if (i_sum[MAN_W+4]) begin
      w_norm  = {i_sum[MAN_W+4:2], i_sum[1] | i_sum[0]};
      w_exp_n = $signed({2'b00, i_exp}) + EXP_ONE;
    end else begin
      w_norm  = i_sum[MAN_W+3:0] << w_lzc;
      w_exp_n = $signed({2'b00, i_exp}) - $signed({{(EW-LZ_W){1'b0}}, w_lzc});
    end

    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r   = {1'b0, w_norm[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
    // A rounding carry leaves 10...0, so the shifted fraction is zero.
    w_frac     = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    w_exp_r    = w_mant_r[MAN_W+1] ? (w_exp_n + EXP_ONE) : w_exp_n;

    o_overflow = 1'b0;
    o_inexact  = |w_norm[2:0];
    if (i_sum == '0) begin
      o_res     = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      o_inexact = 1'b0;
    end else if (w_exp_r >= EXP_MAX) begin
      o_res      = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_overflow = 1'b1;
    end else if (w_exp_r < EXP_ONE) begin
      o_res     = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      o_inexact = 1'b1;
    end else begin
      o_res = {i_sign, w_exp_r[EXP_W-1:0], w_frac};
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754 add/subtract: align, add, normalise/round.
// Whole pipeline freezes while the output holds an unaccepted result.
module fadd_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] res,
  output logic [TAG_W-1:0]     out_tag,
  output logic [2:0]           flags
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int XW = MAN_W + 4;
  localparam int SP = sign_pos(EXP_W, MAN_W);
  localparam int EP = exp_pos(MAN_W);
  localparam logic [W-1:0]     QNAN = W'(qnan_pat(EXP_W, MAN_W));
  localparam logic [W-1:0]     INF  = W'(inf_pat(EXP_W, MAN_W));
  localparam logic [EXP_W:0]   XW_E = (EXP_W+1)'(XW);

  logic                 r1_valid, r2_valid, r3_valid;
  logic [TAG_W-1:0]     r1_tag, r2_tag, r3_tag;
  logic                 r1_special, r2_special, r1_spec_inv, r2_spec_inv;
  logic [W-1:0]         r1_spec_res, r2_spec_res, r3_res;
  logic                 r1_sign, r2_sign, r1_sub;
  logic [EXP_W-1:0]     r1_exp, r2_exp;
  logic [XW-1:0]        r1_ml, r1_ms;
  logic [XW:0]          r2_sum;
  logic [2:0]           r3_flags;

  logic                 w_stall;
  logic                 w_sa, w_sb, w_sl, w_swap;
  logic [EXP_W-1:0]     w_ea, w_eb, w_el, w_es;
  logic [MAN_W-1:0]     w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [W-2:0]         w_mag_a, w_mag_b;
  logic [MAN_W:0]       w_sig_a, w_sig_b, w_ml, w_ms;
  logic [EXP_W:0]       w_diff, w_sh;
  logic [2*XW-1:0]      w_wide;
  logic [XW-1:0]        w_ms_al;
  logic                 w_special, w_spec_inv;
  logic [W-1:0]         w_spec_res;
  logic [XW:0]          w_sum;
  logic [W-1:0]         w_nr_res, w_res;
  logic                 w_nr_ovf, w_nr_inx;
  logic [2:0]           w_flags;

  assign w_stall   = r3_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r3_valid;
  assign res       = r3_res;
  assign out_tag   = r3_tag;
  assign flags     = r3_flags;

  // S1: decode, flush subnormals, order by magnitude, align the smaller operand.
  assign w_sa     = a[SP];
  assign w_sb     = b[SP] ^ mode;
  assign w_ea     = a[SP-1:EP];
  assign w_eb     = b[SP-1:EP];
  assign w_fa     = a[EP-1:0];
  assign w_fb     = b[EP-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_mag_a  = w_a_zero ? '0 : a[W-2:0];
  assign w_mag_b  = w_b_zero ? '0 : b[W-2:0];
  assign w_sig_a  = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_sig_b  = w_b_zero ? '0 : {1'b1, w_fb};
  assign w_swap   = w_mag_b > w_mag_a;
  assign w_sl     = w_swap ? w_sb : w_sa;
  assign w_el     = w_swap ? w_eb : w_ea;
  assign w_es     = w_swap ? w_ea : w_eb;
  assign w_ml     = w_swap ? w_sig_b : w_sig_a;
  assign w_ms     = w_swap ? w_sig_a : w_sig_b;
  assign w_diff   = {1'b0, w_el} - {1'b0, w_es};
  assign w_sh     = (w_diff > XW_E) ? XW_E : w_diff;
  // Lower half of the wide shift collects everything pushed past the sticky bit.
  assign w_wide   = {w_ms, 3'b000, {XW{1'b0}}} >> w_sh;
  assign w_ms_al  = {w_wide[2*XW-1:XW+1], w_wide[XW] | (|w_wide[XW-1:0])};

  always_comb begin
    w_special  = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan) begin
      w_special  = 1'b1;
      w_spec_res = QNAN;
    end else if (w_a_inf && w_b_inf) begin
      w_special  = 1'b1;
      w_spec_inv = (w_sa != w_sb);
      w_spec_res = (w_sa != w_sb) ? QNAN : {w_sa, INF[W-2:0]};
    end else if (w_a_inf || w_b_inf) begin
      w_special  = 1'b1;
      w_spec_res = w_a_inf ? {w_sa, INF[W-2:0]} : {w_sb, INF[W-2:0]};
    end else if (w_a_zero && w_b_zero) begin
      w_special  = 1'b1;
      w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
    end
  end

  // S2: effective add/subtract; |larger| >= |smaller| keeps the difference non-negative.
  assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms}) : ({1'b0, r1_ml} + {1'b0, r1_ms});

  // S3
  fp_norm_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_norm_round (
    .i_sign    (r2_sign),
    .i_exp     (r2_exp),
    .i_sum     (r2_sum),
    .o_res     (w_nr_res),
    .o_overflow(w_nr_ovf),
    .o_inexact (w_nr_inx)
  );

  always_comb begin
    w_flags = '0;
    w_res   = r2_special ? r2_spec_res : w_nr_res;
    if (r2_special) begin
      w_flags[FLAG_INVALID] = r2_spec_inv;
    end else begin
      w_flags[FLAG_OVERFLOW] = w_nr_ovf;
      w_flags[FLAG_INEXACT]  = w_nr_inx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r3_res   <= '0;
      r3_tag   <= '0;
      r3_flags <= '0;
    end else if (!w_stall) begin
      r1_valid <= in_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
      r3_res   <= w_res;
      r3_tag   <= r2_tag;
      r3_flags <= w_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r1_tag      <= in_tag;
      r1_special  <= w_special;
      r1_spec_inv <= w_spec_inv;
      r1_spec_res <= w_spec_res;
      r1_sign     <= w_sl;
      r1_exp      <= w_el;
      r1_sub      <= w_sa ^ w_sb;
      r1_ml       <= {w_ml, 3'b000};
      r1_ms       <= w_ms_al;
      r2_tag      <= r1_tag;
      r2_special  <= r1_special;
      r2_spec_inv <= r1_spec_inv;
      r2_spec_res <= r1_spec_res;
      r2_sign     <= (w_sum == '0) ? 1'b0 : r1_sign;
      r2_exp      <= r1_exp;
      r2_sum      <= w_sum;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe (binary32): arithmetic, rounding, specials,
// backpressure ordering and mid-flight reset.
module tb_fadd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  out_tag;
  logic [2:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  fadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .out_tag  (out_tag),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one op into an idle pipeline with out_ready high and waits for its result.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic im,
                        input logic [3:0] it, output logic [31:0] ores,
                        output logic [2:0] ofl, output logic [3:0] otag, output int lat);
    bit got;
    @(negedge clk);
    a = ia; b = ib; mode = im; in_tag = it; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (out_valid) got = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) lat = -1;
    ores = res; ofl = flags; otag = out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = 1'b0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got=%h exp=00000000", res); end
    n_tests++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
    n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags); end
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    logic [31:0] r; logic [2:0] f; logic [3:0] t; int lat;
    run_op(32'h3f800000, 32'h40000000, 1'b0, 4'h5, r, f, t, lat);
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL add_res got=%h exp=40400000", r); end
    n_tests++; if (f !== 3'b000) begin n_fail++; $display("FAIL add_flags got=%b exp=000", f); end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got=%0d exp=3", lat); end
    n_tests++; if (t !== 4'h5) begin n_fail++; $display("FAIL add_tag got=%h exp=5", t); end
  endtask

  task automatic test_rounding();
    logic [31:0] va[8], vb[8], vr[8];
    logic        vm[8];
    logic [2:0]  vf[8];
    logic [31:0] r; logic [2:0] f; logic [3:0] t; int lat;
    va = '{32'h3f800000, 32'h3f800000, 32'h3f800001, 32'h3f800000,
           32'h40000000, 32'h3f800000, 32'h00800001, 32'h00000001};
    vb = '{32'h3f800000, 32'h33800000, 32'h33800000, 32'h33c00000,
           32'h3f800000, 32'h40000000, 32'h00800000, 32'h3f800000};
    vm = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vr = '{32'h00000000, 32'h3f800000, 32'h3f800002, 32'h3f800001,
           32'h3f800000, 32'hbf800000, 32'h00000000, 32'h3f800000};
    vf = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vm[i], 4'(i), r, f, t, lat);
      n_tests++;
      if (r !== vr[i]) begin n_fail++; $display("FAIL round_res[%0d] got=%h exp=%h", i, r, vr[i]); end
      n_tests++;
      if (f !== vf[i]) begin n_fail++; $display("FAIL round_flags[%0d] got=%b exp=%b", i, f, vf[i]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va[8], vb[8], vr[8];
    logic        vm[8];
    logic [2:0]  vf[8], mk[8];
    logic [31:0] r; logic [2:0] f; logic [3:0] t; int lat;
    va = '{32'h7f800000, 32'h7f7fffff, 32'h7fc00000, 32'h7f800000,
           32'h80000000, 32'h00000000, 32'h7f800000, 32'h3f800000};
    vb = '{32'hff800000, 32'h7f7fffff, 32'h3f800000, 32'h3f800000,
           32'h80000000, 32'h00000000, 32'h7f800000, 32'h7f800000};
    vm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vr = '{32'h7fc00000, 32'h7f800000, 32'h7fc00000, 32'h7f800000,
           32'h80000000, 32'h00000000, 32'h7fc00000, 32'hff800000};
    vf = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    mk = '{3'b111, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vm[i], 4'(i), r, f, t, lat);
      n_tests++;
      if (r !== vr[i]) begin n_fail++; $display("FAIL special_res[%0d] got=%h exp=%h", i, r, vr[i]); end
      n_tests++;
      if ((f & mk[i]) !== vf[i]) begin
        n_fail++; $display("FAIL special_flags[%0d] got=%b exp=%b mask=%b", i, f, vf[i], mk[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vb[8], vr[8];
    int idx, n_out, n_low;
    bit acc, exp_rdy;
    vb = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
    vr = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
           32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};
    idx = 0; n_out = 0; n_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      if (idx < 8) begin
        a = 32'h3f800000; b = vb[idx]; mode = 1'b0; in_tag = 4'(idx); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(c >= 4 && c <= 6);
      if (!in_ready) n_low++;
      n_tests++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready[c%0d] got=%b exp=%b", c, in_ready, exp_rdy); end
      if (out_valid) begin
        if (n_out >= 8) begin
          n_tests++; n_fail++; $display("FAIL b2b_extra_output got=tag %h exp=none", out_tag);
        end else begin
          n_tests++;
          if (out_tag !== 4'(n_out)) begin n_fail++; $display("FAIL b2b_tag[c%0d] got=%h exp=%h", c, out_tag, 4'(n_out)); end
          n_tests++;
          if (res !== vr[n_out]) begin n_fail++; $display("FAIL b2b_res[c%0d] got=%h exp=%h", c, res, vr[n_out]); end
        end
        if (out_ready) n_out++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    out_ready = 1'b1;
    n_tests++; if (n_out !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", n_out); end
    n_tests++; if (idx !== 8) begin n_fail++; $display("FAIL b2b_accepted got=%0d exp=8", idx); end
    n_tests++; if (n_low !== 3) begin n_fail++; $display("FAIL b2b_stall_cycles got=%0d exp=3", n_low); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] r; logic [2:0] f; logic [3:0] t; int lat, n_spur;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 32'h3f800000; b = 32'h3f800000; mode = 1'b0; in_tag = 4'(10 + k); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_out_valid got=%b exp=1", out_valid); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL rst_async_res got=%h exp=00000000", res); end
    @(negedge clk);
    rst = 1'b0;
    n_spur = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) n_spur++;
    end
    n_tests++; if (n_spur !== 0) begin n_fail++; $display("FAIL rst_discard got=%0d outputs exp=0", n_spur); end
    run_op(32'h3f800000, 32'h40000000, 1'b0, 4'h9, r, f, t, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rst_post_latency got=%0d exp=3", lat); end
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL rst_post_res got=%h exp=40400000", r); end
    n_tests++; if (t !== 4'h9) begin n_fail++; $display("FAIL rst_post_tag got=%h exp=9", t); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
